// File: rtl/word_writer.sv
// word_writer: serialises letter codes into 3-row pixel columns framed by blank columns.
module word_writer #(
  parameter int GAP = 1
) (
  input  logic       clk,
  input  logic       restart,
  input  logic [1:0] letter,
  input  logic       last,
  input  logic       valid,
  output logic       ready,
  output logic [2:0] bits,
  output logic       col_valid,
  output logic       busy
);
  typedef enum logic [1:0] {S_IDLE, S_GAP, S_GLYPH, S_TAIL} state_t;
  state_t     state, state_n;
  logic [2:0] gcnt, gcnt_n, col;
  logic [1:0] idx, idx_n, let_q, let_n, fin;
  logic       last_q, last_n, final_col, gap_done, accept;
  always_comb begin
    fin       = let_q == 2'b00 ? 2'd0 : let_q == 2'b01 ? 2'd1 : 2'd2;
    final_col = idx == fin;
    gap_done  = gcnt == 3'(GAP - 1);
    col       = let_q == 2'b00 ? 3'b111 :
                let_q == 2'b01 ? (idx == 2'd0 ? 3'b111 : 3'b001) :
                let_q == 2'b10 ? (idx == 2'd1 ? 3'b111 : 3'b100) :
                                 (idx == 2'd1 ? 3'b010 : 3'b111);
    ready     = restart && (state == S_IDLE || (state == S_GLYPH && final_col && !last_q));
    accept    = valid && ready;
    bits      = state == S_GLYPH ? col : 3'b000;
    col_valid = state != S_IDLE;
    busy      = state != S_IDLE;
  end
  always_comb begin
    state_n = state;
    gcnt_n  = gcnt;
    idx_n   = idx;
    let_n   = let_q;
    last_n  = last_q;
    if (accept) begin
      state_n = S_GAP;
      gcnt_n  = 3'd0;
      let_n   = letter;
      last_n  = last;
    end else begin
      case (state)
        S_GAP: begin
          gcnt_n = gcnt + 3'd1;
          if (gap_done) begin
            state_n = S_GLYPH;
            idx_n   = 2'd0;
          end
        end
        S_GLYPH: begin
          idx_n  = idx + 2'd1;
          gcnt_n = 3'd0;
          if (final_col) state_n = last_q ? S_TAIL : S_IDLE;
        end
        S_TAIL: begin
          gcnt_n = gcnt + 3'd1;
          if (gap_done) state_n = S_IDLE;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or negedge restart) begin
    if (!restart) begin
      state  <= S_IDLE;
      gcnt   <= 3'd0;
      idx    <= 2'd0;
      let_q  <= 2'd0;
      last_q <= 1'b0;
    end else begin
      state  <= state_n;
      gcnt   <= gcnt_n;
      idx    <= idx_n;
      let_q  <= let_n;
      last_q <= last_n;
    end
  end
endmodule

// File: tb/tb_word_writer.sv
// tb_word_writer: randomized letter stream checked by a column-queue scoreboard.
module tb_word_writer;
  localparam int G = 2;
  logic       clk = 1'b0, restart = 1'b0, last = 1'b0, valid = 1'b0;
  logic [1:0] letter = 2'b00;
  logic       ready, col_valid, busy;
  logic [2:0] bits;
  int         n_cmp = 0, n_err = 0;
  typedef struct packed { logic [2:0] b; logic r; } ent_t;
  ent_t q[$];

  word_writer #(.GAP(G)) dut (
    .clk(clk), .restart(restart), .letter(letter), .last(last), .valid(valid),
    .ready(ready), .bits(bits), .col_valid(col_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Expected column sequence of one letter, straight from the glyph table.
  function automatic void push_letter(input logic [1:0] l, input logic ls);
    logic [2:0] glyph[4][3] = '{'{3'b111, 3'b000, 3'b000}, '{3'b111, 3'b001, 3'b000},
                               '{3'b100, 3'b111, 3'b100}, '{3'b111, 3'b010, 3'b111}};
    int len[4] = '{1, 2, 3, 3};
    for (int i = 0; i < G; i++) q.push_back('{3'b000, 1'b0});
    for (int i = 0; i < len[l]; i++) q.push_back('{glyph[l][i], (i == len[l] - 1) && !ls});
    if (ls) for (int i = 0; i < G; i++) q.push_back('{3'b000, 1'b0});
  endfunction

  // Monitor: the model decides what ready/col_valid/bits must be at every column.
  initial forever begin
    @(negedge clk);
    if (!restart) begin
      chk("reset_outputs", {bits, col_valid}, 4'h0);
      chk("reset_ready_busy", {2'b00, ready, busy}, 4'h0);
      q.delete();
    end else begin
      chk("ready", {3'b000, ready}, {3'b000, q.size() == 0 || q[0].r});
      chk("col_valid", {3'b000, col_valid}, {3'b000, q.size() != 0});
      chk("busy", {3'b000, busy}, {3'b000, q.size() != 0});
      if (q.size() != 0) begin
        chk("bits", {1'b0, bits}, {1'b0, q[0].b});
        void'(q.pop_front());
      end
      if (valid && ready) push_letter(letter, last);
    end
  end

  task automatic send(input logic [1:0] l, input logic ls, input int idle);
    logic acc = 1'b0;
    letter = l;
    last   = ls;
    valid  = 1'b1;
    for (int i = 0; i < 40 && !acc; i++) begin
      @(negedge clk);
      acc = ready;
      @(posedge clk);
      #2;
    end
    if (!acc) chk("accept_timeout", 4'h0, 4'h1);
    if (idle > 0) begin
      valid  = 1'b0;
      letter = 2'($urandom_range(3));
      last   = 1'($urandom_range(1));
      repeat (idle) @(posedge clk);
      #2;
    end
  endtask

  initial begin
    #1 chk("async_reset_ready", {3'b000, ready}, 4'h0);
    repeat (2) @(posedge clk);
    #3 restart = 1'b1;
    #1 chk("ready_after_release", {3'b000, ready}, 4'h1);
    @(posedge clk);
    #2;
    send(2'b00, 1'b1, 3);
    send(2'b10, 1'b1, 0);
    send(2'b11, 1'b1, 4);
    send(2'b11, 1'b0, 0);
    send(2'b00, 1'b1, 6);
    send(2'b01, 1'b0, 6);
    send(2'b01, 1'b0, 0);
    valid = 1'b0;
    repeat (G) @(posedge clk);
    #3 restart = 1'b0;
    #1 chk("async_bits_col_valid", {bits, col_valid}, 4'h0);
    chk("async_ready_busy", {2'b00, ready, busy}, 4'h0);
    @(posedge clk);
    #3 restart = 1'b1;
    #1 chk("ready_same_cycle", {3'b000, ready}, 4'h1);
    @(posedge clk);
    #2;
    send(2'b10, 1'b1, 2);
    for (int k = 0; k < 150; k++)
      send(2'($urandom_range(3)), $urandom_range(3) == 0,
           $urandom_range(2) == 0 ? int'($urandom_range(5)) : 0);
    valid = 1'b0;
    repeat (25) @(posedge clk);
    #2 chk("drained", {3'b000, col_valid}, 4'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
